// File: rtl/route_distributor_ctrl.sv
// route_distributor_ctrl
//
// Sequential slot scheduler for the route distributor. It accepts a
// channel-request mask and hands out capacitor slots one per cycle. The
// lowest requesting channel is served first, and slots fill upward from
// slot 0. It then presents the finished slot map to the distributor array.
//
// State table:
//   state | meaning
//   IDLE  | waiting for a mask; previous map outputs hold
//   ALLOC | one slot assigned per cycle from the pending vector
//   DONE  | map complete and stable, waiting for map_ready
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   cfg_valid  request mask valid (accepted only in IDLE)
//   cfg_ready  high in IDLE
//   cfg_mask   bit i = channel i requests a slot
//   abort      cancel allocation or discard map (ALLOC/DONE)
//   map_valid  high in DONE
//   map_ready  consumer accepts the map
//   cap_sel    slot s channel index at [s*CH_W +: CH_W]
//   cap_used   thermometer of occupied slots
//   alloc_cnt  number of slots assigned
//   overflow   more requests than slots; the excess was dropped
//   busy       state is not IDLE
module route_distributor_ctrl #(
    parameter int CHANNEL_NUM   = 128,
    parameter int CAPACITOR_NUM = 70,
    parameter int CH_W          = 7,
    parameter int CNT_W         = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [CHANNEL_NUM-1:0]        cfg_mask,
    input  logic                          abort,
    output logic                          map_valid,
    input  logic                          map_ready,
    output logic [CAPACITOR_NUM*CH_W-1:0] cap_sel,
    output logic [CAPACITOR_NUM-1:0]      cap_used,
    output logic [CNT_W-1:0]              alloc_cnt,
    output logic                          overflow,
    output logic                          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CAP_MAX = CNT_W'(CAPACITOR_NUM);

    state_t                 state;
    logic [CHANNEL_NUM-1:0] pend;
    logic [CHANNEL_NUM-1:0] pend_rest;
    logic [CH_W-1:0]        idx;
    logic [CNT_W-1:0]       cnt_inc;

    // Lowest set bit of pend. Scanning from the top lets the last hit win,
    // which leaves the lowest index in idx.
    always_comb begin
        idx = '0;
        for (int i = CHANNEL_NUM - 1; i >= 0; i--) begin
            if (pend[i]) idx = CH_W'(i);
        end
    end

    // Pending vector as it will look after this cycle's assignment.
    always_comb begin
        pend_rest      = pend;
        pend_rest[idx] = 1'b0;
    end

    assign cnt_inc = alloc_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= '0;
            cap_sel   <= '0;
            cap_used  <= '0;
            alloc_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        pend      <= cfg_mask;
                        cap_sel   <= '0;
                        cap_used  <= '0;
                        alloc_cnt <= '0;
                        overflow  <= 1'b0;
                        state     <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (abort) begin
                        pend      <= '0;
                        cap_sel   <= '0;
                        cap_used  <= '0;
                        alloc_cnt <= '0;
                        overflow  <= 1'b0;
                        state     <= IDLE;
                    end else if (pend == '0 || alloc_cnt >= CAP_MAX) begin
                        state <= DONE;
                    end else begin
                        cap_sel[int'(alloc_cnt)*CH_W +: CH_W] <= idx;
                        cap_used[alloc_cnt]                   <= 1'b1;
                        pend                                  <= pend_rest;
                        alloc_cnt                             <= cnt_inc;
                        if (pend_rest == '0) begin
                            state <= DONE;
                        end else if (cnt_inc == CAP_MAX) begin
                            // Slots exhausted with requests still pending.
                            overflow <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (abort) begin
                        pend      <= '0;
                        cap_sel   <= '0;
                        cap_used  <= '0;
                        alloc_cnt <= '0;
                        overflow  <= 1'b0;
                        state     <= IDLE;
                    end else if (map_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cfg_ready = (state == IDLE);
    assign map_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_route_distributor_ctrl.sv
module tb_route_distributor_ctrl;

    localparam int CHN = 128;
    localparam int CAP = 70;
    localparam int CHW = 7;
    localparam int CNW = 7;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CHN-1:0]     cfg_mask;
    logic               abort;
    logic               map_valid;
    logic               map_ready;
    logic [CAP*CHW-1:0] cap_sel;
    logic [CAP-1:0]     cap_used;
    logic [CNW-1:0]     alloc_cnt;
    logic               overflow;
    logic               busy;

    int errors = 0;
    int checks = 0;

    route_distributor_ctrl #(
        .CHANNEL_NUM(CHN), .CAPACITOR_NUM(CAP), .CH_W(CHW), .CNT_W(CNW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mask(cfg_mask), .abort(abort), .map_valid(map_valid),
        .map_ready(map_ready), .cap_sel(cap_sel), .cap_used(cap_used),
        .alloc_cnt(alloc_cnt), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [CHW-1:0] slot(input logic [CAP*CHW-1:0] v, input int s);
        return v[s*CHW +: CHW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a mask for one edge; returns with the DUT just past the accept edge.
    task automatic send_cfg(input logic [CHN-1:0] m);
        cfg_mask  = m;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Count edges until map_valid rises (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!map_valid && n < 200) begin
            tick();
            n++;
        end
        if (!map_valid) begin
            errors++;
            $display("FAIL wait_done: map_valid still %0b after %0d cycles, want 1", map_valid, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_mask = '0; abort = 1'b0; map_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++;
        if ({cfg_ready, map_valid, busy, overflow} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 1000", {cfg_ready, map_valid, busy, overflow});
        end
        checks++;
        if (alloc_cnt !== 0 || cap_used !== '0 || cap_sel !== '0) begin
            errors++;
            $display("FAIL reset_map: cnt=%0d used=%h sel=%h want all 0", alloc_cnt, cap_used, cap_sel);
        end
    endtask

    task automatic test_basic();
        logic [CHN-1:0] m;
        int n;
        m = '0; m[0] = 1'b1; m[2] = 1'b1; m[127] = 1'b1;
        map_ready = 1'b1;
        send_cfg(m);
        wait_done(n);
        checks++;
        if (n !== 3) begin
            errors++; $display("FAIL basic_latency: got %0d want 3", n);
        end
        checks++;
        if (slot(cap_sel, 0) !== 7'd0 || slot(cap_sel, 1) !== 7'd2 || slot(cap_sel, 2) !== 7'd127) begin
            errors++;
            $display("FAIL basic_slots: got %0d %0d %0d want 0 2 127",
                     slot(cap_sel, 0), slot(cap_sel, 1), slot(cap_sel, 2));
        end
        checks++;
        if (cap_used !== 70'b111 || alloc_cnt !== 7'd3 || overflow !== 1'b0 || (cap_sel >> 21) !== '0) begin
            errors++;
            $display("FAIL basic_map: used=%h cnt=%0d ovf=%b want 7 3 0", cap_used, alloc_cnt, overflow);
        end
        tick();
        map_ready = 1'b0;
        checks++;
        if (map_valid !== 1'b0 || cfg_ready !== 1'b1 || alloc_cnt !== 7'd3) begin
            errors++;
            $display("FAIL basic_return: valid=%b ready=%b cnt=%0d want 0 1 3", map_valid, cfg_ready, alloc_cnt);
        end
    endtask

    task automatic test_overflow();
        int n;
        int bad;
        map_ready = 1'b1;
        send_cfg('1);
        wait_done(n);
        checks++;
        if (n !== 70) begin
            errors++; $display("FAIL ovf_latency: got %0d want 70", n);
        end
        bad = 0;
        for (int s = 0; s < CAP; s++) if (slot(cap_sel, s) !== CHW'(s)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL ovf_slots: %0d slots wrong, want 0", bad);
        end
        checks++;
        if (cap_used !== {CAP{1'b1}} || alloc_cnt !== 7'd70 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_map: used=%h cnt=%0d ovf=%b want all-ones 70 1", cap_used, alloc_cnt, overflow);
        end
        tick();
        map_ready = 1'b0;
    endtask

    task automatic test_exact_fill();
        logic [CHN-1:0] m;
        int n;
        int bad;
        m = '0;
        for (int i = 0; i < 70; i++) m[i] = 1'b1;
        map_ready = 1'b1;
        send_cfg(m);
        wait_done(n);
        checks++;
        if (n !== 70 || alloc_cnt !== 7'd70 || overflow !== 1'b0) begin
            errors++; $display("FAIL fill_low: n=%0d cnt=%0d ovf=%b want 70 70 0", n, alloc_cnt, overflow);
        end
        tick();
        m = '0;
        for (int i = 58; i < 128; i++) m[i] = 1'b1;
        send_cfg(m);
        wait_done(n);
        bad = 0;
        for (int s = 0; s < CAP; s++) if (slot(cap_sel, s) !== CHW'(58 + s)) bad++;
        checks++;
        if (bad !== 0 || overflow !== 1'b0 || alloc_cnt !== 7'd70) begin
            errors++;
            $display("FAIL fill_high: bad=%0d ovf=%b cnt=%0d want 0 0 70", bad, overflow, alloc_cnt);
        end
        tick();
        map_ready = 1'b0;
    endtask

    task automatic test_empty();
        int n;
        map_ready = 1'b0;
        send_cfg('0);
        wait_done(n);
        checks++;
        if (n !== 1 || alloc_cnt !== 0 || cap_used !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL empty: n=%0d cnt=%0d used=%h ovf=%b want 1 0 0 0", n, alloc_cnt, cap_used, overflow);
        end
        map_ready = 1'b1;
        tick();
        map_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [CHN-1:0] m;
        int n;
        int bad;
        m = '0; m[5] = 1'b1; m[9] = 1'b1;
        map_ready = 1'b0;
        send_cfg(m);
        wait_done(n);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                cfg_mask = '0; cfg_mask[1] = 1'b1; cfg_valid = 1'b1;
            end
            tick();
            cfg_valid = 1'b0;
            if (map_valid !== 1'b1 || cfg_ready !== 1'b0 || alloc_cnt !== 7'd2 ||
                slot(cap_sel, 0) !== 7'd5 || slot(cap_sel, 1) !== 7'd9 || cap_used !== 70'b11)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL hold_done: %0d cycles disturbed, want 0", bad);
        end
        map_ready = 1'b1;
        tick();
        map_ready = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1 || map_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release: ready=%b valid=%b want 1 0", cfg_ready, map_valid);
        end
        m = '0; m[1] = 1'b1;
        send_cfg(m);
        wait_done(n);
        checks++;
        if (n !== 1 || alloc_cnt !== 7'd1 || slot(cap_sel, 0) !== 7'd1) begin
            errors++;
            $display("FAIL hold_next: n=%0d cnt=%0d slot0=%0d want 1 1 1", n, alloc_cnt, slot(cap_sel, 0));
        end
        map_ready = 1'b1;
        tick();
        map_ready = 1'b0;
    endtask

    task automatic test_abort();
        logic [CHN-1:0] m;
        int n;
        send_cfg('1);
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (alloc_cnt !== 7'd4) begin
            errors++; $display("FAIL abort_pre: cnt=%0d want 4", alloc_cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || alloc_cnt !== 0 || cap_used !== '0 ||
            cap_sel !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL abort_alloc: ready=%b busy=%b cnt=%0d used=%h want 1 0 0 0",
                     cfg_ready, busy, alloc_cnt, cap_used);
        end
        send_cfg('1);
        for (int c = 0; c < 4; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || alloc_cnt !== 0 || cap_used !== '0 ||
            cap_sel !== '0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_alloc: ready=%b busy=%b cnt=%0d used=%h want 1 0 0 0",
                     cfg_ready, busy, alloc_cnt, cap_used);
        end
        // abort wins over map_ready in DONE and clears the map
        m = '0; m[3] = 1'b1;
        send_cfg(m);
        wait_done(n);
        abort = 1'b1; map_ready = 1'b1;
        tick();
        abort = 1'b0; map_ready = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1 || alloc_cnt !== 0 || cap_used !== '0 || cap_sel !== '0) begin
            errors++;
            $display("FAIL abort_done: ready=%b cnt=%0d used=%h want 1 0 0", cfg_ready, alloc_cnt, cap_used);
        end
        // abort in IDLE is ignored; the mask is taken
        abort = 1'b1;
        send_cfg(m);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL abort_idle: busy=%b want 1", busy);
        end
        wait_done(n);
        map_ready = 1'b1;
        tick();
        map_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_exact_fill();
        test_empty();
        test_backpressure();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
